reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Parametrised register file replacing individual per-register blocks in the datapath: NUM_REGS registers of WIDTH bits.
- One write port (C bus), one increment channel (PC/AR-style auto-increment) and two independent registered read ports (A and B buses).
- Read ports drive valid-qualified data instead of high-impedance, so A/B buses are muxed, not tri-stated.
- Sits between the control unit (addresses and enables) and the ALU operand buses.

Parameters:
- WIDTH, 16, data width of each register and of every data port
- NUM_REGS, 8, number of registers, 2..64
- ADDR_W, max(1, clog2(NUM_REGS)), address width (derived; not overridden by the user)
- ZERO_REG, 0, if 1 then register 0 is hardwired to zero

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- wr_en  in  1  write-port enable
- wr_addr  in  ADDR_W  write register index
- wr_data  in  WIDTH  write data (C bus)
- inc_en  in  1  increment enable
- inc_addr  in  ADDR_W  register to increment
- rd_en_a  in  1  read enable, port A
- rd_addr_a  in  ADDR_W  read index, port A
- rd_data_a  out  WIDTH  port A data (A bus), registered
- rd_valid_a  out  1  port A data valid
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: same as port A, for port B

Behaviour:
- Reset: on a rising edge with reset==0, all registers, rd_data_a/b and rd_valid_a/b go to 0. Reset overrides every other input in that cycle, including a write or read in flight.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data.
- Increment: on a rising edge with inc_en=1, reg[inc_addr] <= reg[inc_addr]+1, modulo 2^WIDTH. All-ones wraps to 0 with no carry output.
- Write and increment to the same address in the same cycle: the write wins and the increment is dropped. Different addresses: both take effect.
- Read latency is 1 cycle. If rd_en_x=1 at edge N, then after edge N:
  - rd_data_x = value of reg[rd_addr_x] after edge N's update (write-first bypass; includes a same-cycle write or increment).
  - rd_valid_x = 1.
- Read idle: if rd_en_x=0 at edge N, rd_valid_x=0 after edge N and rd_data_x holds its previous value.
- Ports A and B are fully independent. Both may read the same address, which returns identical data.
- ZERO_REG=1: writes and increments to address 0 are ignored, and reads of address 0 return 0.
- Out-of-range address (>= NUM_REGS, possible when NUM_REGS is not a power of 2): write/increment ignored; read returns 0 with rd_valid_x=1.
- No combinational path from any input to any output.

Decomposition:
- Shared package (datapath pkg):
  - default WIDTH and NUM_REGS constants;
  - a clog2-style address-width function;
  - register index constants used by control (e.g. PC, AR, AC indices).
- One natural sub-module: reg_file_cell, one WIDTH-bit register with write, increment and synchronous clear, priority clear > write > increment. It is instantiated NUM_REGS times in a generate loop; the top level holds only address decode and the two read-port output registers.

Test Plan:
- Reset mid-operation: write 16'hBEEF to reg 3, then assert reset=0 in the same cycle as rd_en_a=1, rd_addr_a=3 -> next cycle rd_data_a=0, rd_valid_a=0; a later read of reg 3 returns 0.
- Write then read: write 16'h1234 to reg 5 at edge N; rd_en_b=1, rd_addr_b=5 at edge N+1 -> rd_data_b=16'h1234, rd_valid_b=1 after N+1.
- Bypass: at the same edge write 16'hA5A5 to reg 2 and read reg 2 on both ports -> after that edge rd_data_a=rd_data_b=16'hA5A5, both valid=1.
- Increment wrap and conflict:
  - reg 1=16'hFFFF, inc_en on reg 1 -> reads 16'h0000;
  - same edge wr_en and inc_en on reg 4 with wr_data=16'h0010 -> reg 4=16'h0010.
- ZERO_REG=1, NUM_REGS=6: write 16'h7777 to reg 0 and to address 6 -> read reg 0 gives 0; read address 6 gives 0 with valid=1; regs 1..5 unchanged.
- Idle hold: read reg 5 (16'h1234), then drop rd_en_a while writing 16'h9999 to reg 5 -> rd_valid_a=0, rd_data_a stays 16'h1234.

Source files
------------

// File: rtl/reg_file_2r1w_pkg.sv
// Shared datapath definitions for the register file and the control unit.
// Holds default sizing, the address-width helper and the well-known register indices.
// No logic; pure constants and a constant function.
package reg_file_2r1w_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NUM_REGS = 8;

  // Register indices the control unit uses for its dedicated registers.
  localparam int REG_AC = 1;
  localparam int REG_AR = 2;
  localparam int REG_PC = 3;

  // Bits needed to address n registers; never less than one bit.
  function automatic int addr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_file_cell.sv
// One WIDTH-bit register: synchronous clear > write > increment (wraps modulo 2^WIDTH).
// Latency: state updates on the rising edge; nxt_o is the value the register takes at that edge.
// No backpressure; every enabled operation is accepted in the cycle it is presented.
module reg_file_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdat_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] nxt_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value ignoring clear: write beats increment.
  always_comb begin
    data_d = data_q;
    if (we_i) begin
      data_d = wdat_i;
    end else if (inc_i) begin
      data_d = data_q + WIDTH'(1);
    end
  end

  // State register with synchronous clear taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Exposed so the read ports can return the post-edge value (write-first bypass).
  assign nxt_o = data_d;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file: NUM_REGS x WIDTH, one write port, one increment channel, two registered read ports.
// Read latency 1 cycle with write-first bypass; outputs are valid-qualified, data held while idle.
// No backpressure; all requests are serviced in the cycle they are presented.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid_b
);

  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] inc_hit;
  logic [WIDTH-1:0]    nxt_val [NUM_REGS];

  logic [WIDTH-1:0] rd_data_a_d, rd_data_a_q;
  logic [WIDTH-1:0] rd_data_b_d, rd_data_b_q;
  logic             rd_valid_a_q, rd_valid_b_q;

  // Address decode; out-of-range addresses match nothing, and register 0 is locked when hardwired.
  always_comb begin
    wr_hit  = '0;
    inc_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        wr_hit[i]  = wr_en  && (wr_addr  == ADDR_W'(i));
        inc_hit[i] = inc_en && (inc_addr == ADDR_W'(i));
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_cell
      reg_file_cell #(.WIDTH(WIDTH)) u_cell (
        .clk_i  (clk),
        .clr_i  (!reset),
        .we_i   (wr_hit[g]),
        .wdat_i (wr_data),
        .inc_i  (inc_hit[g]),
        .nxt_o  (nxt_val[g])
      );
    end
  endgenerate

  // Read muxes on post-edge values; unmatched (out-of-range) or hardwired-zero addresses give 0.
  always_comb begin
    rd_data_a_d = '0;
    rd_data_b_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        if (rd_addr_a == ADDR_W'(i)) rd_data_a_d = nxt_val[i];
        if (rd_addr_b == ADDR_W'(i)) rd_data_b_d = nxt_val[i];
      end
    end
  end

  // Read-port output registers: valid follows the enable, data only loads on a read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_valid_a_q <= rd_en_a;
      rd_valid_b_q <= rd_en_b;
      if (rd_en_a) rd_data_a_q <= rd_data_a_d;
      if (rd_en_b) rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_b = rd_valid_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: default instance (8 regs) and a ZERO_REG instance with 6 regs.
// Directed table of vectors with fixed expectations, then random traffic against a reference model.
// Every cycle both instances are compared against the model.
module tb_reg_file_2r1w;

  typedef struct {
    bit          rst;   // level driven on reset (0 = reset)
    bit          we;
    logic [2:0]  wa;
    logic [15:0] wd;
    bit          ie;
    logic [2:0]  ia;
    bit          rea;
    logic [2:0]  raa;
    bit          reb;
    logic [2:0]  rab;
  } vec_t;

  typedef struct {
    int          sel;
    vec_t        v;
    bit          ca;
    logic [15:0] eda;
    bit          eva;
    bit          cb;
    logic [15:0] edb;
    bit          evb;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 signals
  logic        a_reset, a_wr_en, a_inc_en, a_rd_en_a, a_rd_en_b, a_rd_valid_a, a_rd_valid_b;
  logic [2:0]  a_wr_addr, a_inc_addr, a_rd_addr_a, a_rd_addr_b;
  logic [15:0] a_wr_data, a_rd_data_a, a_rd_data_b;
  // Instance 1 signals
  logic        z_reset, z_wr_en, z_inc_en, z_rd_en_a, z_rd_en_b, z_rd_valid_a, z_rd_valid_b;
  logic [2:0]  z_wr_addr, z_inc_addr, z_rd_addr_a, z_rd_addr_b;
  logic [15:0] z_wr_data, z_rd_data_a, z_rd_data_b;

  reg_file_2r1w #(.WIDTH(16), .NUM_REGS(8), .ZERO_REG(0)) u_dut (
    .clk(clk), .reset(a_reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .inc_en(a_inc_en), .inc_addr(a_inc_addr),
    .rd_en_a(a_rd_en_a), .rd_addr_a(a_rd_addr_a), .rd_data_a(a_rd_data_a), .rd_valid_a(a_rd_valid_a),
    .rd_en_b(a_rd_en_b), .rd_addr_b(a_rd_addr_b), .rd_data_b(a_rd_data_b), .rd_valid_b(a_rd_valid_b)
  );

  reg_file_2r1w #(.WIDTH(16), .NUM_REGS(6), .ZERO_REG(1)) u_dz (
    .clk(clk), .reset(z_reset),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .inc_en(z_inc_en), .inc_addr(z_inc_addr),
    .rd_en_a(z_rd_en_a), .rd_addr_a(z_rd_addr_a), .rd_data_a(z_rd_data_a), .rd_valid_a(z_rd_valid_a),
    .rd_en_b(z_rd_en_b), .rd_addr_b(z_rd_addr_b), .rd_data_b(z_rd_data_b), .rd_valid_b(z_rd_valid_b)
  );

  // Reference model: register contents and expected port outputs per instance.
  logic [15:0] m    [2][8];
  logic [15:0] ed_a [2];
  logic [15:0] ed_b [2];
  bit          ev_a [2];
  bit          ev_b [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{rst: 1'b1, we: 1'b0, wa: 3'd0, wd: 16'h0, ie: 1'b0, ia: 3'd0,
          rea: 1'b0, raa: 3'd0, reb: 1'b0, rab: 3'd0};
    return v;
  endfunction

  task automatic drive(input int s, input vec_t v);
    if (s == 0) begin
      a_reset = v.rst; a_wr_en = v.we; a_wr_addr = v.wa; a_wr_data = v.wd;
      a_inc_en = v.ie; a_inc_addr = v.ia;
      a_rd_en_a = v.rea; a_rd_addr_a = v.raa; a_rd_en_b = v.reb; a_rd_addr_b = v.rab;
    end else begin
      z_reset = v.rst; z_wr_en = v.we; z_wr_addr = v.wa; z_wr_data = v.wd;
      z_inc_en = v.ie; z_inc_addr = v.ia;
      z_rd_en_a = v.rea; z_rd_addr_a = v.raa; z_rd_en_b = v.reb; z_rd_addr_b = v.rab;
    end
  endtask

  // Apply one clock edge of the rules to the model of instance s.
  task automatic model_step(input int s, input vec_t v);
    int n;
    bit z;
    logic [15:0] nw [8];
    n = (s == 0) ? 8 : 6;
    z = (s == 1);
    if (!v.rst) begin
      for (int k = 0; k < 8; k++) m[s][k] = 16'h0;
      ed_a[s] = 16'h0; ed_b[s] = 16'h0; ev_a[s] = 1'b0; ev_b[s] = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) nw[k] = m[s][k];
      if (v.ie && int'(v.ia) < n && !(z && v.ia == 3'd0) && !(v.we && v.wa == v.ia))
        nw[v.ia] = m[s][v.ia] + 16'd1;
      if (v.we && int'(v.wa) < n && !(z && v.wa == 3'd0))
        nw[v.wa] = v.wd;
      for (int k = 0; k < 8; k++) m[s][k] = nw[k];
      ev_a[s] = v.rea;
      ev_b[s] = v.reb;
      if (v.rea) ed_a[s] = (int'(v.raa) < n) ? nw[v.raa] : 16'h0;
      if (v.reb) ed_b[s] = (int'(v.rab) < n) ? nw[v.rab] : 16'h0;
    end
  endtask

  task automatic check_model();
    chk("i0 rd_data_a vs model",  a_rd_data_a, ed_a[0]);
    chk("i0 rd_valid_a vs model", {15'h0, a_rd_valid_a}, {15'h0, ev_a[0]});
    chk("i0 rd_data_b vs model",  a_rd_data_b, ed_b[0]);
    chk("i0 rd_valid_b vs model", {15'h0, a_rd_valid_b}, {15'h0, ev_b[0]});
    chk("i1 rd_data_a vs model",  z_rd_data_a, ed_a[1]);
    chk("i1 rd_valid_a vs model", {15'h0, z_rd_valid_a}, {15'h0, ev_a[1]});
    chk("i1 rd_data_b vs model",  z_rd_data_b, ed_b[1]);
    chk("i1 rd_valid_b vs model", {15'h0, z_rd_valid_b}, {15'h0, ev_b[1]});
  endtask

  // One cycle: drive at the falling edge, update the model at the rising edge, sample 1ns later.
  task automatic run_vec(input int s, input vec_t v);
    vec_t other;
    other = idle_vec();
    @(negedge clk);
    drive(s, v);
    drive(1 - s, other);
    @(posedge clk);
    model_step(s, v);
    model_step(1 - s, other);
    #1;
    check_model();
  endtask

  function automatic rec_t mk(input int sel, input bit rst,
                              input bit we, input logic [2:0] wa, input logic [15:0] wd,
                              input bit ie, input logic [2:0] ia,
                              input bit rea, input logic [2:0] raa, input bit reb, input logic [2:0] rab,
                              input bit ca, input logic [15:0] eda, input bit eva,
                              input bit cb, input logic [15:0] edb, input bit evb);
    rec_t r;
    r.sel = sel;
    r.v = '{rst: rst, we: we, wa: wa, wd: wd, ie: ie, ia: ia, rea: rea, raa: raa, reb: reb, rab: rab};
    r.ca = ca; r.eda = eda; r.eva = eva;
    r.cb = cb; r.edb = edb; r.evb = evb;
    return r;
  endfunction

  rec_t tbl [$];

  initial begin
    vec_t v;
    rec_t r;
    string nm;

    // Power-up: hold both instances in reset for two edges.
    drive(0, idle_vec());
    drive(1, idle_vec());
    a_reset = 1'b0;
    z_reset = 1'b0;
    repeat (2) @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) m[s][k] = 16'h0;
      ed_a[s] = 16'h0; ed_b[s] = 16'h0; ev_a[s] = 1'b0; ev_b[s] = 1'b0;
    end

    //          sel rst we wa    wd        ie ia    rea raa   reb rab   ca eda       eva cb edb       evb
    tbl.push_back(mk(0, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd0, 1, 3'd0, 1, 16'h0000, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 1, 3'd3, 16'hBEEF, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd3, 0, 3'd0, 1, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd3, 0, 3'd0, 1, 16'h0000, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 1, 3'd5, 16'h1234, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd0, 1, 3'd5, 0, 16'h0000, 0, 1, 16'h1234, 1));
    tbl.push_back(mk(0, 1, 1, 3'd2, 16'hA5A5, 0, 3'd0, 1, 3'd2, 1, 3'd2, 1, 16'hA5A5, 1, 1, 16'hA5A5, 1));
    tbl.push_back(mk(0, 1, 1, 3'd1, 16'hFFFF, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 16'h0000, 1, 3'd1, 1, 3'd1, 0, 3'd0, 1, 16'h0000, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 1, 3'd4, 16'h0010, 1, 3'd4, 0, 3'd0, 1, 3'd4, 0, 16'h0000, 0, 1, 16'h0010, 1));
    tbl.push_back(mk(0, 1, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd5, 0, 3'd0, 1, 16'h1234, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 1, 3'd5, 16'h9999, 0, 3'd0, 0, 3'd5, 0, 3'd0, 1, 16'h1234, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd5, 1, 3'd4, 1, 16'h9999, 1, 1, 16'h0010, 1));
    // Hardwired-zero, 6-register instance.
    tbl.push_back(mk(1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 16'h0000, 0, 1, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1, 3'd1, 16'h1111, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1, 3'd5, 16'h5555, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1, 3'd0, 16'h7777, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1, 3'd6, 16'h7777, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd0, 1, 3'd6, 1, 16'h0000, 1, 1, 16'h0000, 1));
    tbl.push_back(mk(1, 1, 0, 3'd0, 16'h0000, 0, 3'd0, 1, 3'd1, 1, 3'd5, 1, 16'h1111, 1, 1, 16'h5555, 1));
    tbl.push_back(mk(1, 1, 0, 3'd0, 16'h0000, 1, 3'd0, 1, 3'd0, 0, 3'd0, 1, 16'h0000, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1, 3'd7, 16'h2222, 1, 3'd6, 0, 3'd0, 1, 3'd7, 0, 16'h0000, 0, 1, 16'h0000, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      run_vec(r.sel, r.v);
      if (r.sel == 0) begin
        if (r.ca) begin
          $sformat(nm, "row%0d rd_data_a", i);  chk(nm, a_rd_data_a, r.eda);
          $sformat(nm, "row%0d rd_valid_a", i); chk(nm, {15'h0, a_rd_valid_a}, {15'h0, r.eva});
        end
        if (r.cb) begin
          $sformat(nm, "row%0d rd_data_b", i);  chk(nm, a_rd_data_b, r.edb);
          $sformat(nm, "row%0d rd_valid_b", i); chk(nm, {15'h0, a_rd_valid_b}, {15'h0, r.evb});
        end
      end else begin
        if (r.ca) begin
          $sformat(nm, "row%0d rd_data_a", i);  chk(nm, z_rd_data_a, r.eda);
          $sformat(nm, "row%0d rd_valid_a", i); chk(nm, {15'h0, z_rd_valid_a}, {15'h0, r.eva});
        end
        if (r.cb) begin
          $sformat(nm, "row%0d rd_data_b", i);  chk(nm, z_rd_data_b, r.edb);
          $sformat(nm, "row%0d rd_valid_b", i); chk(nm, {15'h0, z_rd_valid_b}, {15'h0, r.evb});
        end
      end
    end

    // Randomized traffic on both instances; addresses cover out-of-range values for the 6-reg one.
    for (int i = 0; i < 600; i++) begin
      v.rst = ($urandom_range(0, 40) != 0);
      v.we  = ($urandom_range(0, 1) == 1);
      v.wa  = 3'($urandom_range(0, 7));
      v.wd  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      v.ie  = ($urandom_range(0, 2) != 0);
      v.ia  = ($urandom_range(0, 3) == 0) ? v.wa : 3'($urandom_range(0, 7));
      v.rea = ($urandom_range(0, 3) != 0);
      v.raa = ($urandom_range(0, 2) == 0) ? v.wa : 3'($urandom_range(0, 7));
      v.reb = ($urandom_range(0, 3) != 0);
      v.rab = ($urandom_range(0, 2) == 0) ? v.ia : 3'($urandom_range(0, 7));
      run_vec(i % 2, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
